mux_serializer: RTL and testbench
=================================

# mux_serializer

Upstream sequencer for the team's 16:1 mux. Accepts a 16-bit parallel word over a valid/ready handshake, then walks the select index 0..15 and presents one selected bit per transfer on a serial valid/ready output. The block drives `sel_out` so a 16:1 mux can be attached externally, and it also produces the selected bit internally on `ser_out`.

## Interface
- `WIDTH`, 16, parallel word width; power of two, ≥2
- `SEL_W`, 4, select width; equals $clog2(WIDTH)
- `MSB_FIRST`, 0, 0 sends index 0 first; 1 sends index WIDTH-1 first

Ports:
- `clk`  in  1  single clock; rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  parallel word available
- `in_ready`  out  1  block can accept a word this cycle
- `in_data`  in  WIDTH  parallel word; sampled on accept
- `sel_out`  out  SEL_W  current select index, for an external mux
- `ser_out`  out  1  bit of the held word at `sel_out`
- `ser_valid`  out  1  `ser_out` is valid
- `ser_ready`  in  1  downstream accepts the bit
- `ser_last`  out  1  current bit is the final bit of the word
- `busy`  out  1  a word is held (state RUN)

## Operation
- States: IDLE and RUN.
- IDLE:
  - `in_ready`=1, `ser_valid`=0.
  - On the accept condition (`in_valid`&&`in_ready`), register `in_data` into `data_q`, set `sel_out` to its start index, and go to RUN.
  - Start index is 0 when `MSB_FIRST`=0, and WIDTH-1 when `MSB_FIRST`=1.
- RUN:
  - `ser_valid`=1 and `ser_out`=`data_q[sel_out]`.
  - On a transfer (`ser_valid`&&`ser_ready`), `sel_out` steps by +1, or by −1 when `MSB_FIRST`=1.
  - `ser_last`=1 when `sel_out` is at its end index: WIDTH-1, or 0 when `MSB_FIRST`=1.
- Last-bit transfer:
  - If `in_valid`=1 at the same edge, load the new word, reset `sel_out` to the start index, and stay in RUN. There is no bubble.
  - Otherwise go to IDLE.
- `in_ready` = (state==IDLE) || (`ser_last` && `ser_ready`). It is combinational from registered state and `ser_ready`.
- Backpressure: when `ser_ready`=0, `sel_out`, `data_q`, `ser_out` and `ser_last` all hold.
- `data_q` is written only on accept. `in_data` changing mid-word has no effect.
- `sel_out` never wraps on its own; it is reloaded only on accept.
- Reset (any time, including mid-word):
  - State goes to IDLE; `data_q`=0, `sel_out`=0.
  - Outputs: `in_ready`=1, `ser_valid`=0, `ser_last`=0, `ser_out`=0, `busy`=0.
  - The partial word is discarded and is not resumed after reset.

## Timing
- Latency: the word is accepted at edge N; its first bit is valid in cycle N+1.
- Throughput: one bit per cycle with `ser_ready`=1. A word takes WIDTH cycles.
- Back-to-back words run with zero idle cycles.
- After a last bit with no pending word, `ser_valid` falls the next cycle. `in_ready` is already 1 in that cycle.
- `ser_out`, `ser_last` and `sel_out` change only on clock edges. Downstream may sample them combinationally from registers.

## Structure
- Package `mux_ser_pkg` holds:
  - state encoding localparams: IDLE=1'b0, RUN=1'b1
  - default WIDTH and SEL_W
  - start/end index helper constants
- Sub-module `sel_counter` holds the loadable up/down SEL_W counter: load, enable, direction, and a `last` flag.
- Top level holds the FSM, `data_q`, the handshake logic and the bit select.
- Estimated size: about 150–250 lines of RTL in total.

## Test plan
- Reset mid-word:
  - Stimulus: assert `rst_n`=0 at bit 7 of a word.
  - Required: outputs immediately `ser_valid`=0, `sel_out`=0, `in_ready`=1.
  - Required: the next accepted word starts at index 0.
- Single word, LSB first:
  - Stimulus: `in_data`=16'hAAAB, `ser_ready`=1.
  - Required serial stream (index 0→15): 1,1,0,1,0,1,0,1,0,1,0,1,0,1,0,1.
  - Required: `ser_last` asserted only on the 16th bit; IDLE on the following cycle.
- MSB first:
  - Stimulus: `MSB_FIRST`=1, 16'hAAAB.
  - Required: `sel_out` counts 15→0; stream is 1,0,1,0,1,0,1,0,1,0,1,0,1,0,1,1.
- Backpressure:
  - Stimulus: hold `ser_ready`=0 for 3 cycles at `sel_out`=5.
  - Required: `sel_out`=5 and `ser_out` are stable throughout.
  - Required: the total word completes in exactly 19 cycles.
- Back-to-back:
  - Stimulus: 16'hAAAB then 16'h5555, with `in_valid` held continuously.
  - Required: 32 consecutive `ser_valid` cycles and two `ser_last` pulses.
  - Required: `in_ready` is high only on the cycle of the first word's last bit.
- Full sweep:
  - Stimulus: a random word, with a reference-model compare of every `sel_out`/`ser_out` pair over 1000 words and random `ser_ready`.

Source files
------------

// File: rtl/mux_ser_pkg.sv
// mux_ser_pkg: shared state encoding, default sizes and select start/end index helpers
//   IDLE/RUN   : FSM state encoding
//   DEF_WIDTH  : default parallel word width
//   DEF_SEL_W  : default select width
//   start_idx  : first select index of a word for a given bit order
//   end_idx    : final select index of a word for a given bit order
package mux_ser_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEL_W = 4;
    function automatic int start_idx(input int width, input bit msb_first);
        return msb_first ? width - 1 : 0;
    endfunction
    function automatic int end_idx(input int width, input bit msb_first);
        return msb_first ? 0 : width - 1;
    endfunction
endpackage

// File: rtl/sel_counter.sv
// sel_counter: loadable up/down select counter with an end-of-range flag
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   load_i     : load start_i (takes priority over en_i)
//   en_i       : step the count by one
//   down_i     : step direction, 1 = decrement
//   start_i    : value loaded on load_i
//   end_i      : value at which last_o is raised
//   cnt_o      : current count
//   last_o     : count equals end_i
module sel_counter
    import mux_ser_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             down_i,
    input  logic [SEL_W-1:0] start_i,
    input  logic [SEL_W-1:0] end_i,
    output logic [SEL_W-1:0] cnt_o,
    output logic             last_o
);
    logic [SEL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load_i ? start_i : en_i ? (down_i ? cnt_q - 1'b1 : cnt_q + 1'b1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign last_o = cnt_q == end_i;
endmodule

// File: rtl/mux_serializer.sv
// mux_serializer: accepts a parallel word and streams its bits out one per serial transfer
//   clk, rst_n : clock, async active-low reset
//   in_valid   : parallel word available
//   in_ready   : word can be accepted this cycle
//   in_data    : parallel word, sampled on accept
//   sel_out    : current select index, for an external WIDTH:1 mux
//   ser_out    : bit of the held word at sel_out
//   ser_valid  : ser_out is valid
//   ser_ready  : downstream accepts the bit
//   ser_last   : current bit is the final bit of the word
//   busy       : a word is held
module mux_serializer
    import mux_ser_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SEL_W     = DEF_SEL_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [SEL_W-1:0] sel_out,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);
    localparam logic [SEL_W-1:0] START = SEL_W'(start_idx(WIDTH, MSB_FIRST));
    localparam logic [SEL_W-1:0] STOP  = SEL_W'(end_idx(WIDTH, MSB_FIRST));

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             cnt_last, xfer, accept;

    sel_counter #(.SEL_W(SEL_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .en_i    (xfer),
        .down_i  (MSB_FIRST),
        .start_i (START),
        .end_i   (STOP),
        .cnt_o   (sel_out),
        .last_o  (cnt_last)
    );

    // the counter's end flag is meaningless while idle (index 0 is the end for MSB-first)
    assign ser_valid = state_q == RUN;
    assign busy      = ser_valid;
    assign ser_last  = ser_valid && cnt_last;
    assign ser_out   = ser_valid && data_q[sel_out];
    assign xfer      = ser_valid && ser_ready;
    assign in_ready  = !ser_valid || (ser_last && ser_ready);
    assign accept    = in_valid && in_ready;

    // an accept on the last-bit transfer keeps RUN, giving back-to-back words with no bubble
    always_comb begin
        state_d = accept ? RUN : (xfer && ser_last) ? IDLE : state_q;
        data_d  = accept ? in_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_mux_serializer.sv
// tb_mux_serializer: self-checking bench driving an LSB-first and an MSB-first instance in lockstep
module tb_mux_serializer;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, ser_ready = 1'b0;
    logic [15:0] in_data = '0;
    logic        ir0, ser0, sv0, sl0, bz0, ir1, ser1, sv1, sl1, bz1;
    logic [3:0]  sel0, sel1;
    int          ncmp = 0, nfail = 0;

    mux_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .sel_out(sel0), .ser_out(ser0), .ser_valid(sv0), .ser_ready(ser_ready),
        .ser_last(sl0), .busy(bz0));

    mux_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .sel_out(sel1), .ser_out(ser1), .ser_valid(sv1), .ser_ready(ser_ready),
        .ser_last(sl1), .busy(bz1));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        rdy;
        logic        ev, eir, el, cs;
        logic [3:0]  s0;
        logic        b0;
        logic [3:0]  s1;
        logic        b1;
    } vec_t;

    vec_t tbl [18];
    bit   exp_lsb [16];
    bit   exp_msb [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic eir, input logic el,
                           input logic cs, input int es0, input logic eb0, input int es1, input logic eb1);
        chk({tag, ".valid0"}, 32'(sv0), 32'(ev));
        chk({tag, ".valid1"}, 32'(sv1), 32'(ev));
        chk({tag, ".busy0"}, 32'(bz0), 32'(ev));
        chk({tag, ".in_ready0"}, 32'(ir0), 32'(eir));
        chk({tag, ".in_ready1"}, 32'(ir1), 32'(eir));
        chk({tag, ".last0"}, 32'(sl0), 32'(el));
        chk({tag, ".last1"}, 32'(sl1), 32'(el));
        if (cs) begin
            chk({tag, ".sel0"}, 32'(sel0), es0);
            chk({tag, ".ser0"}, 32'(ser0), 32'(eb0));
            chk({tag, ".sel1"}, 32'(sel1), es1);
            chk({tag, ".ser1"}, 32'(ser1), 32'(eb1));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] m_word;
        logic        m_busy, e_last, e_ir, acc_now, pend;
        int          m_p, words, stalls, cyc, acc, nval, nlast, ir_cnt, ir_at;
        bit          got [32];

        exp_lsb = '{1,1,0,1,0,1,0,1,0,1,0,1,0,1,0,1};
        exp_msb = '{1,0,1,0,1,0,1,0,1,0,1,0,1,0,1,1};
        tbl[0] = '{iv:1, d:16'hAAAB, rdy:1, ev:0, eir:1, el:0, cs:1, s0:0, b0:0, s1:0, b1:0};
        for (int k = 0; k < 16; k++)
            tbl[k+1] = '{iv:0, d:16'h0000, rdy:1, ev:1, eir:(k == 15), el:(k == 15), cs:1,
                         s0:4'(k), b0:exp_lsb[k], s1:4'(15 - k), b1:exp_msb[k]};
        tbl[17] = '{iv:0, d:16'h0000, rdy:1, ev:0, eir:1, el:0, cs:0, s0:0, b0:0, s1:0, b1:0};

        ser_ready = 1'b1;
        #3;
        chk_out("reset", 0, 1, 0, 1, 0, 0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;

        // single word, both bit orders
        for (int i = 0; i < 18; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            ser_ready = tbl[i].rdy;
            #2;
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eir, tbl[i].el, tbl[i].cs,
                    tbl[i].s0, tbl[i].b0, tbl[i].s1, tbl[i].b1);
            tick();
        end

        // reset at bit 7 of a word
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        chk("midrst.pre_sel0", 32'(sel0), 7);
        #1 rst_n = 1'b0;
        #1;
        chk_out("midrst", 0, 1, 0, 1, 0, 0, 0, 0);
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hF00F;
        tick();
        in_valid = 1'b0;
        #2;
        chk_out("after_rst", 1, 0, 0, 1, 0, 1, 15, 1);
        for (int k = 0; k < 40 && sv0; k++) tick();
        chk("after_rst.drained", 32'(sv0), 0);

        // backpressure: three stalled cycles at index 5
        w         = 16'hC3A5;
        in_valid  = 1'b1;
        in_data   = w;
        ser_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        stalls   = 0;
        cyc      = 0;
        for (int k = 0; k < 40 && sv0; k++) begin
            if (sel0 == 4'd5 && stalls < 3) begin
                ser_ready = 1'b0;
                stalls++;
                chk("bp.sel0", 32'(sel0), 5);
                chk("bp.ser0", 32'(ser0), 32'(w[5]));
                chk("bp.sel1", 32'(sel1), 10);
                chk("bp.ser1", 32'(ser1), 32'(w[10]));
            end else ser_ready = 1'b1;
            cyc++;
            tick();
        end
        ser_ready = 1'b1;
        chk("bp.stalls", stalls, 3);
        chk("bp.cycles", cyc, 19);

        // back-to-back words with in_valid held
        in_valid = 1'b1;
        in_data  = 16'hAAAB;
        acc = 0; nval = 0; nlast = 0; ir_cnt = 0; ir_at = -1;
        for (int k = 0; k < 60; k++) begin
            #2;
            if (acc == 2 && !sv0) break;
            if (sv0) begin
                if (nval < 32) got[nval] = ser0;
                if (sl0) nlast++;
                if (ir0 && nval < 31) begin
                    ir_cnt++;
                    ir_at = nval;
                end
                nval++;
            end else if (acc > 0) begin
                chk("b2b.gap", 32'(sv0), 1);
            end
            pend = in_valid && ir0;
            tick();
            if (pend) begin
                acc++;
                if (acc == 1) in_data = 16'h5555;
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("b2b.accepts", acc, 2);
        chk("b2b.valid_cycles", nval, 32);
        chk("b2b.last_pulses", nlast, 2);
        chk("b2b.in_ready_cnt", ir_cnt, 1);
        chk("b2b.in_ready_at", ir_at, 15);
        for (int i = 0; i < 32; i++) begin
            w = (i < 16) ? 16'hAAAB : 16'h5555;
            chk($sformatf("b2b.bit%0d", i), 32'(got[i]), 32'(w[i % 16]));
        end

        // random sweep against an index-based reference model
        m_busy = 1'b0; m_word = '0; m_p = 0; words = 0;
        for (int k = 0; k < 60000 && words < 1000; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            ser_ready = ($urandom_range(0, 3) != 0);
            #2;
            e_last = m_busy && m_p == 15;
            e_ir   = !m_busy || (e_last && ser_ready);
            chk_out("rnd", m_busy, e_ir, e_last, m_busy, m_p, m_word[m_p], 15 - m_p, m_word[15 - m_p]);
            acc_now = in_valid && e_ir;
            tick();
            if (m_busy && ser_ready) begin
                if (m_p == 15) m_busy = 1'b0;
                else m_p++;
            end
            if (acc_now) begin
                m_busy = 1'b1;
                m_word = in_data;
                m_p    = 0;
                words++;
            end
        end
        chk("rnd.words", words, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
